tick_timer: RTL

Programmable down-counting interval timer that sits directly downstream of the divide-by-20 prescaler. It consumes the prescaler's one-cycle terminal-count pulse as its count enable. It also generates one-shot or periodic expiry events and an interrupt with acknowledge handshake. All logic runs in the prescaler's clock domain.

---
 rtl/tick_timer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/tick_timer.sv
// Programmable down-counting interval timer driven by a prescaler tick pulse.
// Supports one-shot or auto-reload expiry, pause/resume and an interrupt with acknowledge.
module tick_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             held,
  output logic             expire,
  output logic             irq,
  output logic             missed
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_nxt_s;
  logic             mode_r;
  logic             mode_nxt_s;
  logic             expire_set_s;
  logic             running_r;
  logic             held_r;
  logic             expire_r;
  logic             irq_r;
  logic             missed_r;

  // Next-state, counter and expiry decode.
  always_comb begin
    state_nxt_s  = state_r;
    count_nxt_s  = count_r;
    mode_nxt_s   = mode_r;
    expire_set_s = 1'b0;
    if (load) begin
      reload_nxt_s = load_val;
    end else begin
      reload_nxt_s = reload_r;
    end

    case (state_r)
      IDLE: begin
        if (start) begin
          count_nxt_s = load ? load_val : reload_r;
          mode_nxt_s  = periodic;
          state_nxt_s = RUN;
        end else if (load) begin
          count_nxt_s = load_val;
        end else begin
          count_nxt_s = count_r;
        end
      end
      RUN: begin
        // A stop discards any coincident tick.
        if (stop) begin
          state_nxt_s = HOLD;
        end else if (tick) begin
          if (count_r == ONE_C) begin
            expire_set_s = 1'b1;
            if (mode_r) begin
              count_nxt_s = reload_r;
            end else begin
              count_nxt_s = ZERO_C;
              state_nxt_s = IDLE;
            end
          end else begin
            count_nxt_s = count_r - ONE_C;
          end
        end else begin
          count_nxt_s = count_r;
        end
      end
      HOLD: begin
        if (stop) begin
          state_nxt_s = IDLE;
        end else if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers; status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      count_r   <= ZERO_C;
      reload_r  <= ZERO_C;
      mode_r    <= 1'b0;
      running_r <= 1'b0;
      held_r    <= 1'b0;
      expire_r  <= 1'b0;
      irq_r     <= 1'b0;
      missed_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      reload_r  <= reload_nxt_s;
      mode_r    <= mode_nxt_s;
      running_r <= (state_nxt_s == RUN);
      held_r    <= (state_nxt_s == HOLD);
      expire_r  <= expire_set_s;
      irq_r     <= expire_set_s | (irq_r & ~irq_ack);
      missed_r  <= (expire_set_s & irq_r & ~irq_ack) | (missed_r & ~irq_ack);
    end
  end

  assign count   = count_r;
  assign running = running_r;
  assign held    = held_r;
  assign expire  = expire_r;
  assign irq     = irq_r;
  assign missed  = missed_r;

endmodule
